// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, output-VC FSM states and flit field-position helpers.
package noc_pkg;

   localparam int unsigned FLIT_TYPE_W = 2;

   typedef enum logic [1:0] {
      FLIT_HEAD     = 2'b00,
      FLIT_BODY     = 2'b01,
      FLIT_TAIL     = 2'b10,
      FLIT_HEADTAIL = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      VC_IDLE   = 2'b00,
      VC_ACTIVE = 2'b01,
      VC_DRAIN  = 2'b10
   } vc_state_e;

   // LSB position of the VC-id field, which occupies the top VCID_W bits of the flit
   function automatic int unsigned vcid_lsb(input int unsigned dw, input int unsigned vcid_w);
      return dw - vcid_w;
   endfunction

   // LSB position of the flit-type field, directly below the VC id
   function automatic int unsigned type_lsb(input int unsigned dw, input int unsigned vcid_w);
      return dw - vcid_w - FLIT_TYPE_W;
   endfunction

   function automatic flit_type_e flit_type_of(input logic [FLIT_TYPE_W-1:0] bits);
      return flit_type_e'(bits);
   endfunction

   function automatic logic is_tail(input flit_type_e t);
      return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
   endfunction

endpackage

// File: rtl/vc_credit_fsm.sv
// One output VC: credit counter, IDLE/ACTIVE/DRAIN allocation FSM and per-cycle error pulses.
// OUTPUT_VC_ATOMIC_REALLOC_EN: tail parks the VC in DRAIN until every credit has returned.
module vc_credit_fsm
   import noc_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_send,
   input  logic             i_credit,
   input  logic             i_grant,
   input  logic             i_tail,
   output logic             o_avail,
   output logic             o_has_credit,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_err_ovf_c,
   output logic             o_err_unf_c,
   output logic             o_err_proto_c
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

   vc_state_e        r_state;
   vc_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_avail;
   logic             r_has_credit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= VC_IDLE;
         r_cnt        <= FULL;
         r_avail      <= 1'b1;
         r_has_credit <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_avail      <= (w_state_nxt == VC_IDLE);
         r_has_credit <= (w_cnt_nxt != '0);
      end
   end

   // Simultaneous send and credit cancel; saturate at both ends and flag it
   always_comb begin
      w_cnt_nxt   = r_cnt;
      o_err_ovf_c = 1'b0;
      o_err_unf_c = 1'b0;
      if (i_send && !i_credit) begin
         if (r_cnt == '0) o_err_unf_c = 1'b1;
         else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end else if (i_credit && !i_send) begin
         if (r_cnt == FULL) o_err_ovf_c = 1'b1;
         else               w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      o_err_proto_c = 1'b0;
      case (r_state)
         VC_IDLE: begin
            if (i_send)  o_err_proto_c = 1'b1;
            if (i_grant) w_state_nxt   = VC_ACTIVE;
         end
         VC_ACTIVE: begin
            if (i_grant) o_err_proto_c = 1'b1;
            if (i_send && i_tail) begin
`ifdef OUTPUT_VC_ATOMIC_REALLOC_EN
               w_state_nxt = (w_cnt_nxt == FULL) ? VC_IDLE : VC_DRAIN;
`else
               w_state_nxt = VC_IDLE;
`endif
            end
         end
         VC_DRAIN: begin
            if (i_grant) o_err_proto_c = 1'b1;
            if (w_cnt_nxt == FULL) w_state_nxt = VC_IDLE;
         end
         default: w_state_nxt = VC_IDLE;
      endcase
   end

   assign o_avail      = r_avail;
   assign o_has_credit = r_has_credit;
   assign o_cnt        = r_cnt;

endmodule

// File: rtl/output_port_vc_manager.sv
// Output-port bank of per-VC credit/allocation controllers with registered credit return and sticky errors.
// OUTPUT_VC_ATOMIC_REALLOC_EN selects drain-before-reallocation in every VC controller.
module output_port_vc_manager
   import noc_pkg::*;
#(
   parameter  int unsigned NUM_VC    = 4,
   parameter  int unsigned BUF_DEPTH = 8,
   parameter  int unsigned DW        = 32,
   localparam int unsigned VCID_W    = $clog2(NUM_VC),
   localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NUM_VC-1:0]       credit_in,
   input  logic [NUM_VC-1:0]       va_grant,
   input  logic                    flit_valid,
   input  logic [DW-1:0]           flit_dat,
   output logic [NUM_VC-1:0]       vc_avail,
   output logic [NUM_VC-1:0]       vc_has_credit,
   output logic [NUM_VC*CNT_W-1:0] credit_cnt,
   output logic                    err_overflow,
   output logic                    err_underflow,
   output logic                    err_protocol
);

   localparam int unsigned VCID_LSB = vcid_lsb(DW, VCID_W);
   localparam int unsigned TYPE_LSB = type_lsb(DW, VCID_W);

   logic [NUM_VC-1:0] r_credit_q;
   logic              r_err_ovf;
   logic              r_err_unf;
   logic              r_err_proto;
   logic [VCID_W-1:0] w_vcid;
   flit_type_e        w_type;
   logic              w_vcid_ok;
   logic              w_is_tail;
   logic [NUM_VC-1:0] w_send;
   logic [NUM_VC-1:0] w_ovf_c;
   logic [NUM_VC-1:0] w_unf_c;
   logic [NUM_VC-1:0] w_proto_c;
   logic              w_unused_payload;

   assign w_vcid           = flit_dat[VCID_LSB +: VCID_W];
   assign w_type           = flit_type_of(flit_dat[TYPE_LSB +: FLIT_TYPE_W]);
   assign w_vcid_ok        = (32'(w_vcid) < NUM_VC);
   assign w_is_tail        = is_tail(w_type);
   assign w_unused_payload = ^flit_dat[TYPE_LSB-1:0];

   // Credit returns act one cycle after arrival
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_credit_q <= '0;
      else       r_credit_q <= credit_in;
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign w_send[v] = flit_valid & w_vcid_ok & (w_vcid == VCID_W'(v));

      vc_credit_fsm #(
         .BUF_DEPTH (BUF_DEPTH),
         .CNT_W     (CNT_W)
      ) u_vc (
         .clk           (clk),
         .rstn          (rstn),
         .i_send        (w_send[v]),
         .i_credit      (r_credit_q[v]),
         .i_grant       (va_grant[v]),
         .i_tail        (w_is_tail),
         .o_avail       (vc_avail[v]),
         .o_has_credit  (vc_has_credit[v]),
         .o_cnt         (credit_cnt[v*CNT_W +: CNT_W]),
         .o_err_ovf_c   (w_ovf_c[v]),
         .o_err_unf_c   (w_unf_c[v]),
         .o_err_proto_c (w_proto_c[v])
      );
   end

   // Errors are sticky until reset; out-of-range VC ids count as protocol errors
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err_ovf   <= 1'b0;
         r_err_unf   <= 1'b0;
         r_err_proto <= 1'b0;
      end else begin
         r_err_ovf   <= r_err_ovf | (|w_ovf_c);
         r_err_unf   <= r_err_unf | (|w_unf_c);
         r_err_proto <= r_err_proto | (|w_proto_c) | (flit_valid & ~w_vcid_ok);
      end
   end

   assign err_overflow  = r_err_ovf;
   assign err_underflow = r_err_unf;
   assign err_protocol  = r_err_proto;

endmodule

// File: doc/output_port_vc_manager.md
Name: output_port_vc_manager

Overview:
- Per-output-port bank of NUM_VC output-VC controllers for the router output stage.
- Each VC has:
  - a credit counter, initialised to the downstream buffer depth;
  - a 3-state allocation FSM that drives the VC-availability flag seen by the VC allocator;
  - a credit-available flag used by the switch allocator.
- Observes crossbar output flits and downstream credit returns.
- Successor to the single-VC base controller: parametrised VC count and depth, correct credit initialisation, simultaneous-event handling, error flags.

Parameters:
- NUM_VC, 4, number of virtual channels on the output port (>=2)
- BUF_DEPTH, 8, downstream per-VC buffer depth in flits (>=1)
- DW, 32, flit width
- VCID_W, $clog2(NUM_VC), width of flit VC-id field (derived, not overridden)
- CNT_W, $clog2(BUF_DEPTH+1), credit counter width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- credit_in  in  NUM_VC  one-hot-per-VC credit return from downstream; multiple bits may be set in one cycle
- va_grant  in  NUM_VC  VC allocator grant; bit v marks VC v allocated this cycle
- flit_valid  in  1  crossbar output flit valid
- flit_dat  in  DW  flit; [DW-1 -: VCID_W] = VC id, next 2 bits = flit type
- vc_avail  out  NUM_VC  VC free for allocation
- vc_has_credit  out  NUM_VC  credit counter non-zero
- credit_cnt  out  NUM_VC*CNT_W  packed counters, VC0 in LSBs
- err_overflow  out  1  sticky: credit returned to a full counter
- err_underflow  out  1  sticky: flit sent with zero credit
- err_protocol  out  1  sticky: grant to non-IDLE VC, or flit to IDLE VC

Behaviour:
- Reset (async, rstn=0):
  - credit_cnt[v] = BUF_DEPTH.
  - vc_avail = all 1; vc_has_credit = all 1.
  - All FSMs IDLE; all err_* = 0; credit_in register = 0.
  - Reset mid-packet discards all state with no drain.
- Credit path:
  - credit_in is registered once (credit_q); increments apply the cycle after arrival.
  - send[v] = flit_valid & (flit VC id == v).
  - Next count: send & ~credit_q -> cnt-1; credit_q & ~send -> cnt+1; both or neither -> hold.
- Boundary conditions:
  - Decrement at 0: counter holds 0, err_underflow set.
  - Increment at BUF_DEPTH: counter holds, err_overflow set.
  - VC id >= NUM_VC: flit ignored, err_protocol set.
- vc_has_credit[v] is registered: (next cnt != 0).
- FSM per VC: IDLE, ACTIVE, DRAIN; vc_avail[v] = (state == IDLE), registered.
  - IDLE -> ACTIVE on va_grant[v].
  - ACTIVE -> release on send[v] with type TAIL or HEADTAIL; the release target depends on the optional feature.
  - DRAIN -> IDLE when next cnt == BUF_DEPTH.
  - va_grant[v] in ACTIVE or DRAIN: ignored, err_protocol set.
  - send[v] in IDLE: counter still decrements, err_protocol set.
- Single-flit packet (HEADTAIL) releases on its only flit; vc_avail rises the cycle after.
- Error flags are cleared only by reset.
- Flit types are defined in the package: HEAD=00, BODY=01, TAIL=10, HEADTAIL=11.

Optional Feature:
- Macro: OUTPUT_VC_ATOMIC_REALLOC_EN.
- Defined:
  - Tail moves ACTIVE -> DRAIN.
  - The VC is re-offered only after every credit has returned (cnt == BUF_DEPTH).
  - If the counter is already full on the tail cycle's next value, the FSM goes straight to IDLE.
- Undefined:
  - Tail moves ACTIVE -> IDLE directly; DRAIN is unreachable.
  - Credits keep counting independently of the FSM state.

Decomposition:
- Shared package noc_pkg:
  - flit type encodings
  - VC FSM state enum
  - flit field-slice helpers (vcid, type)
- Sub-module vc_credit_fsm (one VC):
  - counter, FSM and per-VC error pulses
  - instantiated NUM_VC times by generate.
- Top level: credit register stage, flit decode, error OR/sticky logic.

Test Plan:
- Reset, then idle 3 cycles -> credit_cnt all 8, vc_avail=4'b1111, vc_has_credit=4'b1111, errors 0.
- Grant VC2; send HEAD, BODY, TAIL on VC2 on consecutive cycles, no credits -> vc_avail[2] low from cycle after grant; cnt2 steps 7, 6, 5.
  - Without macro: vc_avail[2] high cycle after TAIL.
  - With macro: stays low until 3 credit_in[2] pulses; high the cycle cnt2 reaches 8.
- Same cycle: send on VC1 and credit_q[1]=1 -> cnt1 unchanged. Also: credit_in=4'b1011 together with a send on VC3 -> VC0 and VC1 +1, VC3 unchanged, VC2 unchanged.
- Drain VC0 with 8 flits -> vc_has_credit[0]=0. A 9th flit -> cnt0 stays 0, err_underflow=1.
- Credit return to VC1 at cnt=8 -> err_overflow=1, cnt stays 8. va_grant[1] while VC1 ACTIVE -> err_protocol=1.
- Assert rstn=0 mid-packet on VC3 (cnt3=5, ACTIVE) -> next edge sees cnt3=8, vc_avail[3]=1, errors cleared.
